// File: rtl/utf16_encoder_if.sv
// rtl/utf16_encoder_if.sv - code point input stream and UTF-16 unit output stream of utf16_encoder
interface utf16_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [20:0] in_code_point;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_unit;
    logic        out_is_high;

    modport master (
        output in_valid,
        output in_code_point,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_unit,
        input  out_is_high
    );

    modport slave (
        input  in_valid,
        input  in_code_point,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_unit,
        output out_is_high
    );
endinterface

// File: rtl/utf16_encoder.sv
// rtl/utf16_encoder.sv - Unicode scalar to UTF-16 encoder with output FIFO; UTF16_REPLACEMENT_EN emits U+FFFD for rejects
module utf16_encoder #(
    parameter int DEPTH         = 4,
    parameter int ERR_CNT_WIDTH = 8
) (
    input  logic                       clock,
    input  logic                       reset,
    utf16_encoder_if.slave             bus,
    output logic                       error,
    output logic [ERR_CNT_WIDTH-1:0]   error_count,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] wr_ptr_p1;
    logic [PW-1:0] rd_ptr;

    logic          accept;
    logic          pop;
    logic          is_surrogate;
    logic          too_big;
    logic          invalid;
    logic          supplementary;
    logic [19:0]   v;
    logic [1:0]    push_cnt;
    logic [15:0]   unit0;
    logic [15:0]   unit1;

    // in_ready looks only at registered occupancy so a pair always fits
    assign bus.in_ready    = (DEPTH_L - level) >= LW'(2);
    assign bus.out_valid   = level != '0;
    assign bus.out_unit    = mem[rd_ptr];
    assign bus.out_is_high = bus.out_valid && (bus.out_unit[15:10] == 6'b110110);

    assign accept    = bus.in_valid && bus.in_ready;
    assign pop       = bus.out_valid && bus.out_ready;
    assign wr_ptr_p1 = wr_ptr + PW'(1);

    // Modulo 2^20 subtraction is exact for the supplementary range
    assign v = bus.in_code_point[19:0] - 20'h10000;

    always_comb begin
        is_surrogate  = (bus.in_code_point[20:16] == 5'd0) && (bus.in_code_point[15:11] == 5'b11011);
        too_big       = bus.in_code_point > 21'h10FFFF;
        invalid       = is_surrogate || too_big;
        supplementary = !invalid && (bus.in_code_point[20:16] != 5'd0);
        push_cnt      = 2'd0;
        unit0         = bus.in_code_point[15:0];
        unit1         = 16'hDC00 | {6'b0, v[9:0]};
        if (invalid) begin
`ifdef UTF16_REPLACEMENT_EN
            push_cnt = 2'd1;
            unit0    = 16'hFFFD;
`else
            push_cnt = 2'd0;
`endif
        end else if (supplementary) begin
            push_cnt = 2'd2;
            unit0    = 16'hD800 | {6'b0, v[19:10]};
        end else begin
            push_cnt = 2'd1;
        end
        if (!accept) begin
            push_cnt = 2'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            error       <= 1'b0;
            error_count <= '0;
        end else begin
            if (push_cnt != 2'd0) begin
                mem[wr_ptr] <= unit0;
            end
            if (push_cnt == 2'd2) begin
                mem[wr_ptr_p1] <= unit1;
            end
            wr_ptr <= wr_ptr + PW'(push_cnt);
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            level <= level + LW'(push_cnt) - LW'(pop);
            error <= accept && invalid;
            if (accept && invalid && (error_count != '1)) begin
                error_count <= error_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_utf16_encoder.sv
// tb/tb_utf16_encoder.sv - randomized and directed check of utf16_encoder against a queue reference model
module tb_utf16_encoder;
    localparam int DEPTH = 4;
    localparam int ERR_CNT_WIDTH = 8;

    logic                     clock;
    logic                     reset;
    logic                     error;
    logic [ERR_CNT_WIDTH-1:0] error_count;
    logic [$clog2(DEPTH):0]   level;

    utf16_encoder_if ifc ();

    utf16_encoder #(.DEPTH(DEPTH), .ERR_CNT_WIDTH(ERR_CNT_WIDTH)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (ifc.slave),
        .error      (error),
        .error_count(error_count),
        .level      (level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int compared = 0;
    int mismatched = 0;

    int unsigned m_q[$];
    int unsigned m_err_cnt;
    bit          m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: UTF-16 rules in plain arithmetic
    task automatic model_encode(input int unsigned cp);
        int unsigned vv;
        if ((cp >= 32'hD800 && cp <= 32'hDFFF) || cp > 32'h10FFFF) begin
            m_err = 1'b1;
            if (m_err_cnt < 255) m_err_cnt++;
`ifdef UTF16_REPLACEMENT_EN
            m_q.push_back(32'hFFFD);
`endif
        end else if (cp < 32'h10000) begin
            m_q.push_back(cp);
        end else begin
            vv = cp - 32'h10000;
            m_q.push_back(32'hD800 + vv / 1024);
            m_q.push_back(32'hDC00 + vv % 1024);
        end
    endtask

    task automatic tick(input bit v, input int unsigned cp, input bit ordy, input bit rst);
        bit m_ready;
        bit hi;
        ifc.in_valid      = v;
        ifc.in_code_point = cp[20:0];
        ifc.out_ready     = ordy;
        reset             = rst;
        #1;
        if (!rst) begin
            m_ready = (DEPTH - m_q.size()) >= 2;
            check("in_ready", {31'b0, ifc.in_ready}, {31'b0, m_ready});
            check("out_valid", {31'b0, ifc.out_valid}, {31'b0, m_q.size() > 0});
            check("level", {29'b0, level}, m_q.size());
            check("error", {31'b0, error}, {31'b0, m_err});
            check("error_count", {24'b0, error_count}, m_err_cnt);
            hi = (m_q.size() > 0) && (m_q[0] >= 32'hD800) && (m_q[0] <= 32'hDBFF);
            check("out_is_high", {31'b0, ifc.out_is_high}, {31'b0, hi});
            if (m_q.size() > 0) check("out_unit", {16'b0, ifc.out_unit}, m_q[0]);
            m_err = 1'b0;
            if (m_q.size() > 0 && ordy) void'(m_q.pop_front());
            if (v && m_ready) model_encode(cp);
        end else begin
            m_q.delete();
            m_err = 1'b0;
            m_err_cnt = 0;
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    function automatic int unsigned rand_cp();
        int unsigned edges[8] = '{32'hD7FF, 32'hD800, 32'hDFFF, 32'hE000,
                                  32'hFFFF, 32'h10000, 32'h10FFFF, 32'h110000};
        case ($urandom_range(0, 5))
            0: return $urandom_range(0, 127);
            1: return $urandom_range(0, 32'hFFFF);
            2: return $urandom_range(32'hD800, 32'hDFFF);
            3: return $urandom_range(32'h10000, 32'h10FFFF);
            4: return $urandom_range(32'h110000, 32'h1FFFFF);
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    initial begin
        ifc.in_valid = 1'b0;
        ifc.in_code_point = '0;
        ifc.out_ready = 1'b0;
        reset = 1'b1;
        m_err = 1'b0;
        m_err_cnt = 0;
        @(negedge clock);
        tick(0, 0, 0, 1);
        tick(0, 0, 0, 1);
        check("reset_unit", {16'b0, ifc.out_unit}, 32'h0);
        tick(0, 0, 0, 0);

        // Single BMP unit
        tick(1, 32'h41, 0, 0);
        check("bmp_unit", {16'b0, ifc.out_unit}, 32'h0041);
        check("bmp_level", {29'b0, level}, 32'd1);
        tick(0, 0, 1, 0);

        // Surrogate pairs
        tick(1, 32'h1F600, 0, 0);
        check("pair_hi", {16'b0, ifc.out_unit}, 32'hD83D);
        tick(1, 32'h10FFFF, 1, 0);
        check("pair_lo", {16'b0, ifc.out_unit}, 32'hDE00);
        for (int i = 0; i < 4; i++) tick(0, 0, 1, 0);

        // Rejects
        tick(1, 32'hD800, 1, 0);
        tick(1, 32'h110000, 1, 0);
        tick(0, 0, 1, 0);
        check("rej_count", {24'b0, error_count}, 32'd2);
        for (int i = 0; i < 3; i++) tick(0, 0, 1, 0);

        // Fill to full, then drain; second round straddles the pointer wrap
        tick(1, 32'h1F600, 0, 0);
        tick(1, 32'h1F600, 0, 0);
        tick(1, 32'h1F600, 0, 0);
        check("full_level", {29'b0, level}, 32'd4);
        check("full_ready", {31'b0, ifc.in_ready}, 32'd0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);
        tick(1, 32'h41, 1, 0);
        for (int i = 0; i < 3; i++) tick(1, 32'h1F600, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 0, 1, 0);

        // Counter saturation
        for (int i = 0; i < 260; i++) tick(1, 32'h110000 + $urandom_range(0, 1000), 1, 0);
        tick(0, 0, 1, 0);
        check("sat_count", {24'b0, error_count}, 32'hFF);
        tick(1, 32'hFFFF, 0, 0);
        check("ffff_unit", {16'b0, ifc.out_unit}, 32'hFFFF);
        tick(0, 0, 1, 0);

        // Reset mid-stream with input offered
        tick(1, 32'h41, 0, 0);
        tick(1, 32'h1F600, 0, 0);
        check("pre_reset_level", {29'b0, level}, 32'd3);
        tick(1, 32'h1F600, 0, 1);
        check("post_reset_level", {29'b0, level}, 32'd0);
        check("post_reset_count", {24'b0, error_count}, 32'd0);
        tick(1, 32'h20AC, 0, 0);
        check("resume_unit", {16'b0, ifc.out_unit}, 32'h20AC);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            tick($urandom_range(0, 3) != 0, rand_cp(), $urandom_range(0, 2) != 0, 0);
        end
        for (int i = 0; i < 6; i++) tick(0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
